// File: rtl/display_scan_ctrl.sv
// Scan controller for a dual seven-segment display: alternates the two switch digits onto a
// shared decoder. Build with SCAN_BLANK_EN defined to add blanking slots around each anode switch.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 20000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] sw1_digit,
  input  logic [3:0] sw2_digit,
  output logic       select,
  output logic [3:0] hex_out,
  output logic       blank,
  output logic       slot_tick
);

  localparam int unsigned LEN_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (LEN_MAX > 2) ? $clog2(LEN_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {BLANK_A, SHOW_1, BLANK_B, SHOW_2} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_select, w_select_nxt;
  logic [3:0]       r_hex, w_hex_nxt;
  logic             r_blank, w_blank_nxt;
  logic             r_tick, w_tick_nxt;
  logic             w_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= BLANK_A;
      r_cnt    <= '0;
      r_select <= 1'b1;
      r_hex    <= '0;
      r_blank  <= 1'b1;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_select <= w_select_nxt;
      r_hex    <= w_hex_nxt;
      r_blank  <= w_blank_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_select_nxt = r_select;
    w_hex_nxt    = r_hex;
    w_blank_nxt  = r_blank;
    w_tick_nxt   = 1'b0;
    w_last       = (r_state == BLANK_A || r_state == BLANK_B) ? (r_cnt == BLANK_LAST)
                                                              : (r_cnt == SHOW_LAST);
    if (!en) begin
      w_blank_nxt = 1'b1;
    end else begin
      // Re-derived from the state so a resume after a freeze un-blanks a SHOW slot.
      w_blank_nxt = (r_state == BLANK_A || r_state == BLANK_B);
      if (w_last) begin
        w_cnt_nxt = '0;
        unique case (r_state)
          BLANK_A: begin
            w_state_nxt = SHOW_1;
            w_hex_nxt   = sw1_digit;
            w_blank_nxt = 1'b0;
            w_tick_nxt  = 1'b1;
          end
          SHOW_1: begin
            w_state_nxt  = BLANK_B;
            w_select_nxt = 1'b0;
            w_blank_nxt  = 1'b1;
          end
          BLANK_B: begin
            w_state_nxt = SHOW_2;
            w_hex_nxt   = sw2_digit;
            w_blank_nxt = 1'b0;
            w_tick_nxt  = 1'b1;
          end
          SHOW_2: begin
            w_state_nxt  = BLANK_A;
            w_select_nxt = 1'b1;
            w_blank_nxt  = 1'b1;
          end
          default: w_state_nxt = BLANK_A;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  assign blank = r_blank;
`else
  typedef enum logic {SHOW_1, SHOW_2} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_select, w_select_nxt;
  logic [3:0]       r_hex, w_hex_nxt;
  logic             r_tick, w_tick_nxt;

  // Reset parks on the last SHOW_2 count so the first enabled edge enters SHOW_1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= SHOW_2;
      r_cnt    <= SHOW_LAST;
      r_select <= 1'b0;
      r_hex    <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_select <= w_select_nxt;
      r_hex    <= w_hex_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_select_nxt = r_select;
    w_hex_nxt    = r_hex;
    w_tick_nxt   = 1'b0;
    if (en) begin
      if (r_cnt == SHOW_LAST) begin
        w_cnt_nxt  = '0;
        w_tick_nxt = 1'b1;
        unique case (r_state)
          SHOW_1: begin
            w_state_nxt  = SHOW_2;
            w_select_nxt = 1'b0;
            w_hex_nxt    = sw2_digit;
          end
          SHOW_2: begin
            w_state_nxt  = SHOW_1;
            w_select_nxt = 1'b1;
            w_hex_nxt    = sw1_digit;
          end
          default: w_state_nxt = SHOW_1;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  assign blank = 1'b0;
`endif

  assign select    = r_select;
  assign hex_out   = r_hex;
  assign slot_tick = r_tick;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexing scan controller for the dual seven-segment display.
- Sits directly upstream of the 2:1 anode demux and drives its `select` input.
- Presents the selected hex digit to the shared seven-segment decoder, with a blanking gap around each anode switch to suppress ghosting.
- Inputs come from the two 4-bit switch banks.

Parameters:
- REFRESH_DIV, 20000: clk cycles each digit is shown (SHOW slot length); 48 MHz / 20000 = 2.4 kHz per slot. Must be >= 2.
- BLANK_CYCLES, 500: clk cycles of blanking before each SHOW slot. Must be >= 1. Ignored when the optional feature is compiled out.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- en  in  1  scan enable; 0 freezes the scan and blanks the display
- sw1_digit  in  4  hex digit from switch bank 1
- sw2_digit  in  4  hex digit from switch bank 2
- select  out  1  to anode demux; 1 = digit from switch 1, 0 = digit from switch 2
- hex_out  out  4  digit to the seven-segment decoder, registered
- blank  out  1  1 = force all segments off downstream
- slot_tick  out  1  one-cycle pulse on entry to each SHOW state

Behaviour:
- All outputs are registered. Reset is sampled only on a rising clk edge.
- FSM states: BLANK_A, SHOW_1, BLANK_B, SHOW_2. There is one slot counter, cnt, sized to hold max(REFRESH_DIV, BLANK_CYCLES)-1.
- Reset (reset==0 at an edge):
  - state=BLANK_A, cnt=0
  - select=1, blank=1, hex_out=4'h0, slot_tick=0
  - Reset overrides everything, including mid-slot.
- State transitions (only while en==1):
  - A state ends when cnt == length-1.
  - On a transition, cnt goes to 0; otherwise cnt increments.
- BLANK_A, length BLANK_CYCLES:
  - Holds select=1, blank=1.
  - On exit to SHOW_1: hex_out <= sw1_digit, blank <= 0, slot_tick <= 1.
- SHOW_1, length REFRESH_DIV:
  - hex_out holds the captured value; later changes on sw1_digit are ignored until the next SHOW_1.
  - On exit to BLANK_B: select <= 0, blank <= 1. hex_out holds.
- BLANK_B, length BLANK_CYCLES:
  - On exit to SHOW_2: hex_out <= sw2_digit, blank <= 0, slot_tick <= 1.
- SHOW_2, length REFRESH_DIV:
  - On exit to BLANK_A: select <= 1, blank <= 1.
- select changes only on a SHOW->BLANK edge, so the anode never switches while segments are lit.
- slot_tick is 1 only in the first cycle of a SHOW state; otherwise 0.
- Full period = 2*(REFRESH_DIV+BLANK_CYCLES) cycles; defaults give 41000.
- en==0:
  - state and cnt freeze; blank <= 1 at the next edge.
  - select and hex_out hold; slot_tick=0.
- en returning to 1:
  - blank <= (state is a BLANK state); counting resumes from the frozen cnt.
  - No slot_tick is issued on resume.
- Simultaneous en==0 and terminal cnt: the freeze wins and no transition occurs.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - BLANK_A/BLANK_B are removed; blank is constant 0, including when en==0.
  - SHOW_1 exit goes to SHOW_2 in the same edge: select <= 0, hex_out <= sw2_digit, slot_tick <= 1.
  - SHOW_2 exit goes to SHOW_1 correspondingly.
  - Reset values: state=SHOW_2, cnt=REFRESH_DIV-1, select=0, hex_out=4'h0. The first enabled edge after release enters SHOW_1.
  - Period = 2*REFRESH_DIV.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=2, macro defined unless noted):
- Reset: reset=0 for 3 cycles, sw1=4'hA, sw2=4'h5 -> select=1, blank=1, hex_out=4'h0, slot_tick=0.
- Free scan after release:
  - 2 cycles blank (select=1).
  - 4 cycles hex_out=A, blank=0, select=1, slot_tick high in the first of them.
  - 2 cycles select=0, blank=1.
  - 4 cycles hex_out=5, blank=0, select=0.
  - Repeats with period 12.
- Capture stability: sw1 changes A->3 in the 2nd SHOW_1 cycle -> hex_out stays A for that slot and shows 3 in the next SHOW_1.
- Enable freeze: en=0 for 3 cycles starting in the 2nd SHOW_1 cycle -> blank=1, select=1, hex_out=A held. After en=1: blank=0 and exactly 2 more SHOW_1 cycles, then BLANK_B.
- Reset mid-SHOW_2: reset=0 in cycle 10 -> next edge gives select=1, blank=1, hex_out=0; the scan restarts with the BLANK_A sequence.
- Macro undefined: after release, select toggles every 4 cycles, starting at 1 with hex_out=A; blank=0 always; slot_tick is pulsed every 4 cycles.
